// File: rtl/enc_dec_apb_regs.sv
`default_nettype none
// ============================================================================
// Module   : enc_dec_apb_regs
// Purpose  : APB slave register bank (CTRL, DATA_IN, CODEWORD_WIDTH, NOISE)
//            that launches the encoder/decoder core and stalls writes while
//            the core is busy.
// Revision : 1.0 - initial release
// ============================================================================
module enc_dec_apb_regs #(
  parameter int AMBA_ADDR_WIDTH = 20,
  parameter int AMBA_WORD       = 32,
  parameter int DATA_WIDTH      = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       PSEL,
  input  logic                       PENABLE,
  input  logic                       PWRITE,
  input  logic [AMBA_ADDR_WIDTH-1:0] PADDR,
  input  logic [AMBA_WORD-1:0]       PWDATA,
  output logic [AMBA_WORD-1:0]       PRDATA,
  output logic                       PREADY,
  input  logic                       operation_done,
  output logic                       start,
  output logic                       busy,
  output logic [1:0]                 ctrl,
  output logic [DATA_WIDTH-1:0]      data_in,
  output logic [1:0]                 codeword_width,
  output logic [AMBA_WORD-1:0]       noise
);

  // APB protocol states
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETUP  = 2'd1;
  localparam logic [1:0] ST_ACCESS = 2'd2;

  // Register offsets decoded from PADDR[3:2]
  localparam logic [1:0] ADDR_CTRL  = 2'b00;
  localparam logic [1:0] ADDR_DATA  = 2'b01;
  localparam logic [1:0] ADDR_CW    = 2'b10;
  localparam logic [1:0] ADDR_NOISE = 2'b11;

  logic [1:0]           state_q, state_d;
  logic [AMBA_WORD-1:0] ctrl_q, ctrl_d;
  logic [AMBA_WORD-1:0] data_in_q, data_in_d;
  logic [AMBA_WORD-1:0] cw_q, cw_d;
  logic [AMBA_WORD-1:0] noise_q, noise_d;
  logic [AMBA_WORD-1:0] prdata_q, prdata_d;
  logic                 start_q, start_d;
  logic                 busy_q, busy_d;

  logic                 pready;
  logic                 wr_commit;
  logic                 rd_load;
  logic [1:0]           reg_sel;
  logic [AMBA_WORD-1:0] rd_mux;

  assign reg_sel = PADDR[3:2];

  // Bits that are intentionally not decoded or not forwarded to the core
  logic unused_bits;
  assign unused_bits = ^{PADDR[AMBA_ADDR_WIDTH-1:4], PADDR[1:0],
                         ctrl_q[AMBA_WORD-1:2], cw_q[AMBA_WORD-1:2], data_in_q};

  // Output decode: writes stall in ACCESS while the core is busy; reads never stall
  always_comb begin
    pready = 1'b1;
    if (state_q == ST_ACCESS && PWRITE && busy_q) begin
      pready = 1'b0;
    end
  end

  // Next-state logic for the APB transfer FSM
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        // PSEL&PENABLE without a setup phase is not a valid transfer
        if (PSEL && !PENABLE) state_d = ST_SETUP;
      end
      ST_SETUP: begin
        if (!PSEL)             state_d = ST_IDLE;
        else if (PENABLE)      state_d = ST_ACCESS;
      end
      ST_ACCESS: begin
        if (pready) begin
          state_d = (PSEL && !PENABLE) ? ST_SETUP : ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Read mux over the four registers
  always_comb begin
    rd_mux = ctrl_q;
    case (reg_sel)
      ADDR_CTRL:  rd_mux = ctrl_q;
      ADDR_DATA:  rd_mux = data_in_q;
      ADDR_CW:    rd_mux = cw_q;
      ADDR_NOISE: rd_mux = noise_q;
      default:    rd_mux = ctrl_q;
    endcase
  end

  // Register file, read-data capture and core handshake next values
  always_comb begin
    wr_commit = (state_q == ST_ACCESS) && PWRITE && pready;
    rd_load   = (state_q == ST_SETUP) && PSEL && PENABLE && !PWRITE;

    ctrl_d    = ctrl_q;
    data_in_d = data_in_q;
    cw_d      = cw_q;
    noise_d   = noise_q;
    prdata_d  = rd_load ? rd_mux : prdata_q;
    start_d   = 1'b0;
    busy_d    = busy_q;

    // busy only drops on a done pulse from an operation in flight
    if (busy_q && operation_done) busy_d = 1'b0;

    if (wr_commit) begin
      case (reg_sel)
        ADDR_CTRL: begin
          ctrl_d  = PWDATA;
          // commit implies busy_q=0, so this never double-launches the core
          start_d = 1'b1;
          busy_d  = 1'b1;
        end
        ADDR_DATA:  data_in_d = PWDATA;
        ADDR_CW:    cw_d      = PWDATA;
        ADDR_NOISE: noise_d   = PWDATA;
        default:    ctrl_d    = ctrl_q;
      endcase
    end
  end

  // State register; reset aborts any transfer or operation in progress
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      ctrl_q    <= '0;
      data_in_q <= '0;
      cw_q      <= '0;
      noise_q   <= '0;
      prdata_q  <= '0;
      start_q   <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      ctrl_q    <= ctrl_d;
      data_in_q <= data_in_d;
      cw_q      <= cw_d;
      noise_q   <= noise_d;
      prdata_q  <= prdata_d;
      start_q   <= start_d;
      busy_q    <= busy_d;
    end
  end

  assign PRDATA         = prdata_q;
  assign PREADY         = pready;
  assign start          = start_q;
  assign busy           = busy_q;
  assign ctrl           = ctrl_q[1:0];
  assign data_in        = data_in_q[DATA_WIDTH-1:0];
  assign codeword_width = cw_q[1:0];
  assign noise          = noise_q;

endmodule
`default_nettype wire

// File: tb/tb_enc_dec_apb_regs.sv
`default_nettype none
// ============================================================================
// Module   : tb_enc_dec_apb_regs
// Purpose  : Directed self-checking bench for enc_dec_apb_regs
// Revision : 1.0 - initial release
// ============================================================================
module tb_enc_dec_apb_regs;

  logic        clk = 1'b0;
  logic        rst;
  logic        PSEL, PENABLE, PWRITE;
  logic [19:0] PADDR;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        operation_done;
  logic        start, busy;
  logic [1:0]  ctrl, codeword_width;
  logic [31:0] data_in, noise;

  int tests = 0;
  int fails = 0;
  int start_count = 0;

  enc_dec_apb_regs dut (
    .clk(clk), .rst(rst),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY),
    .operation_done(operation_done), .start(start), .busy(busy),
    .ctrl(ctrl), .data_in(data_in), .codeword_width(codeword_width),
    .noise(noise)
  );

  always #5 clk = ~clk;

  // count start pulses seen on any rising edge
  always @(posedge clk) if (start) start_count <= start_count + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // setup + enable phases; returns #1 after entering ACCESS
  task automatic apb_begin(input logic w, input logic [19:0] a, input logic [31:0] d);
    tick();
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = w; PADDR = a; PWDATA = d;
    tick();
    PENABLE = 1'b1;
    tick();
  endtask

  // wait for PREADY (bounded), then complete the transfer
  task automatic apb_end();
    int n = 0;
    while (!PREADY && n < 50) begin
      tick();
      n++;
    end
    check("pready_timeout", {31'd0, (n < 50)}, 32'd1);
    tick();
    PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  task automatic apb_write(input logic [19:0] a, input logic [31:0] d);
    apb_begin(1'b1, a, d);
    apb_end();
  endtask

  task automatic apb_read_check(input string tag, input logic [19:0] a, input logic [31:0] exp);
    apb_begin(1'b0, a, 32'd0);
    check({tag, "_pready"}, {31'd0, PREADY}, 32'd1);
    check(tag, PRDATA, exp);
    apb_end();
  endtask

  initial begin
    rst = 1'b1; PSEL = 0; PENABLE = 0; PWRITE = 0; PADDR = '0; PWDATA = '0;
    operation_done = 1'b0;
    tick(); tick();
    rst = 1'b0;
    #1;

    // reset state
    check("rst_pready", {31'd0, PREADY}, 32'd1);
    check("rst_start",  {31'd0, start},  32'd0);
    check("rst_busy",   {31'd0, busy},   32'd0);
    check("rst_ctrl",   {30'd0, ctrl},   32'd0);
    check("rst_noise",  noise,           32'd0);
    check("rst_prdata", PRDATA,          32'd0);

    // read every offset after reset
    apb_read_check("rd0_ctrl",  20'h00000, 32'h0);
    apb_read_check("rd0_data",  20'h00004, 32'h0);
    apb_read_check("rd0_cw",    20'h00008, 32'h0);
    apb_read_check("rd0_noise", 20'h0000C, 32'h0);

    // enable without setup phase must be ignored
    tick();
    PSEL = 1'b1; PENABLE = 1'b1; PWRITE = 1'b1; PADDR = 20'h00000; PWDATA = 32'h3;
    tick(); tick(); tick();
    PSEL = 1'b0; PENABLE = 1'b0;
    tick();
    check("nosetup_ctrl",  {30'd0, ctrl}, 32'd0);
    check("nosetup_busy",  {31'd0, busy}, 32'd0);
    check("nosetup_start", start_count,   32'd0);
    apb_read_check("nosetup_rd_ctrl", 20'h00000, 32'h0);

    // data registers, with stray upper/lower address bits
    apb_write(20'h10004, 32'hA5A5_00FF);
    apb_write(20'hABC0F, 32'h0000_0101);
    apb_write(20'h00008, 32'h0000_0001);
    check("data_in_out", data_in, 32'hA5A5_00FF);
    check("noise_out",   noise,   32'h0000_0101);
    check("cw_out",      {30'd0, codeword_width}, 32'd1);
    apb_read_check("rd_data",  20'h00004, 32'hA5A5_00FF);
    apb_read_check("rd_noise", 20'h0000C, 32'h0000_0101);
    apb_read_check("rd_cw",    20'h80008, 32'h0000_0001);
    check("data_nostart", start_count, 32'd0);

    // CTRL write launches the core
    apb_write(20'h00000, 32'h1);
    check("ctrl_start_hi", {31'd0, start}, 32'd1);
    check("ctrl_busy_hi",  {31'd0, busy},  32'd1);
    check("ctrl_out",      {30'd0, ctrl},  32'd1);
    tick();
    check("ctrl_start_lo", {31'd0, start}, 32'd0);
    tick(); tick();
    check("ctrl_busy_hold", {31'd0, busy}, 32'd1);
    check("ctrl_start_cnt", start_count,   32'd1);

    // write while busy stalls until the done pulse
    apb_begin(1'b1, 20'h0000C, 32'hFFFF_FFFF);
    check("stall_pready", {31'd0, PREADY}, 32'd0);
    tick(); tick();
    check("stall_pready2", {31'd0, PREADY}, 32'd0);
    check("stall_noise",   noise,           32'h0000_0101);
    operation_done = 1'b1;
    tick();
    operation_done = 1'b0;
    check("done_busy",      {31'd0, busy},   32'd0);
    check("done_pready",    {31'd0, PREADY}, 32'd1);
    check("done_noise_old", noise,           32'h0000_0101);
    apb_end();
    check("stall_noise_new", noise,       32'hFFFF_FFFF);
    check("stall_start_cnt", start_count, 32'd1);

    // stray done pulse while idle
    operation_done = 1'b1;
    tick();
    operation_done = 1'b0;
    check("stray_done_busy", {31'd0, busy}, 32'd0);

    // reset in the middle of a stalled write
    apb_write(20'h00000, 32'h2);
    check("ctrl2_out",  {30'd0, ctrl}, 32'd2);
    check("ctrl2_busy", {31'd0, busy}, 32'd1);
    apb_begin(1'b1, 20'h00004, 32'h0000_1234);
    check("rst_stall_pready", {31'd0, PREADY}, 32'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_busy",   {31'd0, busy},   32'd0);
    check("abort_pready", {31'd0, PREADY}, 32'd1);
    check("abort_ctrl",   {30'd0, ctrl},   32'd0);
    check("abort_data",   data_in,         32'd0);
    check("abort_noise",  noise,           32'd0);
    check("abort_cw",     {30'd0, codeword_width}, 32'd0);
    PSEL = 1'b0; PENABLE = 1'b0;
    tick();
    check("abort_start_cnt", start_count, 32'd2);
    apb_read_check("abort_rd_data", 20'h00004, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
